ifetch_ctrl: RTL and testbench

//  Fetch controller directly downstream of the PC register. Issues one instruction-memory request per PC.

---
 rtl/ifetch_pkg.sv | 11 +
 rtl/ifetch_fifo.sv | 45 ++++
 rtl/ifetch_ctrl.sv | 85 ++++++++
 tb/tb_ifetch_ctrl.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/ifetch_pkg.sv
// ifetch_pkg: widths, FSM state and buffer entry types shared by the fetch controller
package ifetch_pkg;
    localparam int IF_ADDR_W     = 32;
    localparam int IF_INSTR_W    = 32;
    localparam int IF_FIFO_DEPTH = 2;
    typedef enum logic [1:0] {IDLE, WAIT, DROP} fetch_state_e;
    typedef struct packed {
        logic [IF_ADDR_W-1:0]  pc;
        logic [IF_INSTR_W-1:0] instr;
    } fetch_entry_t;
endpackage

// File: rtl/ifetch_fifo.sv
// ifetch_fifo: synchronous fetch buffer of {pc, instr} entries with flush
module ifetch_fifo import ifetch_pkg::*; #(
    parameter int DEPTH = IF_FIFO_DEPTH,
    localparam int PW = DEPTH > 1 ? $clog2(DEPTH) : 1,
    localparam int CW = $clog2(DEPTH) + 1
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          push_i,
    input  logic          pop_i,
    input  logic          flush_i,
    input  fetch_entry_t  data_i,
    output fetch_entry_t  head_o,
    output logic [CW-1:0] count_o
);
    fetch_entry_t mem_q [DEPTH];
    fetch_entry_t mem_d [DEPTH];
    logic [PW-1:0] wr_q, wr_d, rd_q, rd_d;
    logic [CW-1:0] count_q, count_d;
    function automatic logic [PW-1:0] inc(input logic [PW-1:0] p);
        return p == PW'(DEPTH - 1) ? '0 : p + 1'b1;
    endfunction
    always_comb begin
        mem_d = mem_q;
        if (push_i) mem_d[wr_q] = data_i;
        wr_d    = flush_i ? '0 : push_i ? inc(wr_q) : wr_q;
        rd_d    = flush_i ? '0 : pop_i ? inc(rd_q) : rd_q;
        count_d = flush_i ? '0 : count_q + CW'(push_i) - CW'(pop_i);
    end
    always_ff @(posedge clk) begin
        if (reset) begin
            mem_q   <= '{default: '0};
            wr_q    <= '0;
            rd_q    <= '0;
            count_q <= '0;
        end else begin
            mem_q   <= mem_d;
            wr_q    <= wr_d;
            rd_q    <= rd_d;
            count_q <= count_d;
        end
    end
    assign head_o  = mem_q[rd_q];
    assign count_o = count_q;
endmodule

// File: rtl/ifetch_ctrl.sv
// ifetch_ctrl: single-outstanding fetch FSM feeding a {pc, instr} buffer; IFETCH_PERF_EN adds fetch/stall counters
module ifetch_ctrl import ifetch_pkg::*; #(
    parameter int ADDR_W     = IF_ADDR_W,
    parameter int INSTR_W    = IF_INSTR_W,
    parameter int FIFO_DEPTH = IF_FIFO_DEPTH
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [ADDR_W-1:0]  pc_i,
    output logic               pc_en_o,
    input  logic               flush_i,
    output logic               imem_req_o,
    output logic [ADDR_W-1:0]  imem_addr_o,
    input  logic               imem_gnt_i,
    input  logic               imem_rvalid_i,
    input  logic [INSTR_W-1:0] imem_rdata_i,
    output logic               dec_valid_o,
    input  logic               dec_ready_i,
    output logic [ADDR_W-1:0]  dec_pc_o,
    output logic [INSTR_W-1:0] dec_instr_o
`ifdef IFETCH_PERF_EN
    ,
    output logic [31:0]        perf_fetch_cnt_o,
    output logic [31:0]        perf_stall_cnt_o
`endif
);
    localparam int CW = $clog2(FIFO_DEPTH) + 1;
    fetch_state_e state_q, state_d;
    logic [ADDR_W-1:0] req_pc_q, req_pc_d;
    logic [CW-1:0] count;
    logic push, pop;
    fetch_entry_t head;
    // A slot is reserved at request time, so the later push can never overflow
    always_comb begin
        imem_req_o  = ~reset & ~flush_i & (state_q == IDLE) & (count < CW'(FIFO_DEPTH));
        imem_addr_o = pc_i;
        pc_en_o     = imem_req_o & imem_gnt_i;
        push        = (state_q == WAIT) & imem_rvalid_i & ~flush_i;
        dec_valid_o = count != '0;
        pop         = dec_valid_o & dec_ready_i;
        req_pc_d    = pc_en_o ? pc_i : req_pc_q;
        state_d     = state_q == IDLE ? (pc_en_o ? WAIT : IDLE) :
                      imem_rvalid_i ? IDLE :
                      (state_q == WAIT && flush_i) ? DROP : state_q;
        dec_pc_o    = head.pc;
        dec_instr_o = head.instr;
    end
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= IDLE;
            req_pc_q <= '0;
        end else begin
            state_q  <= state_d;
            req_pc_q <= req_pc_d;
        end
    end
    ifetch_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .push_i  (push),
        .pop_i   (pop),
        .flush_i (flush_i),
        .data_i  ({req_pc_q, imem_rdata_i}),
        .head_o  (head),
        .count_o (count)
    );
`ifdef IFETCH_PERF_EN
    logic [31:0] fetch_cnt_q, fetch_cnt_d, stall_cnt_q, stall_cnt_d;
    always_comb begin
        fetch_cnt_d = fetch_cnt_q + 32'(push);
        stall_cnt_d = stall_cnt_q + 32'(dec_ready_i & ~dec_valid_o);
    end
    always_ff @(posedge clk) begin
        if (reset) begin
            fetch_cnt_q <= '0;
            stall_cnt_q <= '0;
        end else begin
            fetch_cnt_q <= fetch_cnt_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end
    assign perf_fetch_cnt_o = fetch_cnt_q;
    assign perf_stall_cnt_o = stall_cnt_q;
`endif
endmodule

// File: tb/tb_ifetch_ctrl.sv
// tb_ifetch_ctrl: directed stimulus with a queue-based reference model checked every cycle
module tb_ifetch_ctrl;
    import ifetch_pkg::*;
    localparam logic [31:0] MAGIC = 32'hC0DE_0000;
    localparam int DEPTH = IF_FIFO_DEPTH;
    logic clk = 0, reset = 1, flush_i = 0, imem_gnt_i = 0, imem_rvalid_i = 0, dec_ready_i = 0;
    logic [31:0] pc_i, imem_rdata_i = 0, imem_addr_o, dec_pc_o, dec_instr_o;
    logic pc_en_o, imem_req_o, dec_valid_o;
`ifdef IFETCH_PERF_EN
    logic [31:0] perf_fetch_cnt_o, perf_stall_cnt_o;
`endif
    ifetch_ctrl dut (
        .clk           (clk),
        .reset         (reset),
        .pc_i          (pc_i),
        .pc_en_o       (pc_en_o),
        .flush_i       (flush_i),
        .imem_req_o    (imem_req_o),
        .imem_addr_o   (imem_addr_o),
        .imem_gnt_i    (imem_gnt_i),
        .imem_rvalid_i (imem_rvalid_i),
        .imem_rdata_i  (imem_rdata_i),
        .dec_valid_o   (dec_valid_o),
        .dec_ready_i   (dec_ready_i),
        .dec_pc_o      (dec_pc_o),
        .dec_instr_o   (dec_instr_o)
`ifdef IFETCH_PERF_EN
        ,
        .perf_fetch_cnt_o (perf_fetch_cnt_o),
        .perf_stall_cnt_o (perf_stall_cnt_o)
`endif
    );
    always #5 clk = ~clk;

    int n_tests = 0, n_fail = 0;
    bit chk_on = 0;
    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %h expected %h", nm, $time, act, exp);
        end
    endtask

    // PC register outside the DUT: advances on pc_en, or is redirected
    bit redir = 0;
    logic [31:0] redir_pc = 0;
    always @(posedge clk)
        if (redir) pc_i <= redir_pc;
        else if (pc_en_o) pc_i <= pc_i + 32'd4;

    // Memory: answers each grant lat cycles later with addr ^ MAGIC
    int lat = 1, cd = 0;
    logic [31:0] raddr = 0;
    always @(posedge clk) begin
        imem_rvalid_i <= 1'b0;
        if (imem_req_o && imem_gnt_i) begin
            raddr = imem_addr_o;
            cd = lat;
        end
        if (cd > 0) begin
            cd--;
            if (cd == 0) begin
                imem_rvalid_i <= 1'b1;
                imem_rdata_i  <= raddr ^ MAGIC;
            end
        end
    end

    // Reference model: pending request flag, discard flag, queue of buffered entries
    logic [63:0] m_q[$];
    bit m_busy = 0, m_disc = 0, m_rq, m_pu, m_po;
    logic [31:0] m_pc = 0;
    int m_fetch = 0, m_stall = 0, cyc = 0;
    int gnt_cyc[$];
    logic [63:0] popped[$];
    function automatic bit e_req();
        return !reset && !flush_i && !m_busy && m_q.size() < DEPTH;
    endfunction
    always @(posedge clk) begin
        cyc++;
        if (pc_en_o) gnt_cyc.push_back(cyc);
        if (dec_valid_o && dec_ready_i) popped.push_back({dec_pc_o, dec_instr_o});
        if (reset) begin
            m_q.delete();
            m_busy = 0; m_disc = 0; m_fetch = 0; m_stall = 0;
        end else begin
            m_rq = e_req();
            m_po = m_q.size() != 0 && dec_ready_i;
            m_pu = m_busy && !m_disc && imem_rvalid_i && !flush_i;
            if (dec_ready_i && m_q.size() == 0) m_stall++;
            if (m_pu) m_fetch++;
            if (flush_i) m_q.delete();
            else begin
                if (m_po) void'(m_q.pop_front());
                if (m_pu) m_q.push_back({m_pc, imem_rdata_i});
            end
            if (m_rq && imem_gnt_i) begin
                m_busy = 1; m_pc = pc_i;
            end else if (m_busy && imem_rvalid_i) begin
                m_busy = 0; m_disc = 0;
            end else if (m_busy && flush_i) m_disc = 1;
        end
    end

    always @(negedge clk) if (chk_on) begin
        chk("imem_req", imem_req_o, e_req());
        chk("pc_en", pc_en_o, e_req() & imem_gnt_i);
        if (e_req()) chk("imem_addr", imem_addr_o, pc_i);
        chk("dec_valid", dec_valid_o, m_q.size() != 0);
        if (m_q.size() != 0) chk("dec_head", {dec_pc_o, dec_instr_o}, m_q[0]);
`ifdef IFETCH_PERF_EN
        chk("perf_fetch", perf_fetch_cnt_o, m_fetch);
        chk("perf_stall", perf_stall_cnt_o, m_stall);
`endif
    end

    task automatic do_reset();
        reset = 1; redir = 1; redir_pc = 0; flush_i = 0;
        repeat (4) @(posedge clk);
        #1 reset = 0; redir = 0;
        gnt_cyc.delete();
        popped.delete();
    endtask

    initial begin
        // 1: streaming at one instruction per two cycles
        imem_gnt_i = 1; dec_ready_i = 1; lat = 1;
        do_reset();
        chk_on = 1;
        @(negedge clk);
        chk("rst_dec_pc", dec_pc_o, 0);
        chk("rst_dec_instr", dec_instr_o, 0);
        chk("rst_dec_valid", dec_valid_o, 0);
        repeat (7) @(posedge clk);
        #1;
        chk("t1_pops", popped.size(), 3);
        chk("t1_pop0", popped[0], {32'h0, 32'h0 ^ MAGIC});
        chk("t1_pop1", popped[1], {32'h4, 32'h4 ^ MAGIC});
        chk("t1_pop2", popped[2], {32'h8, 32'h8 ^ MAGIC});
        chk("t1_gap0", gnt_cyc[1] - gnt_cyc[0], 2);
        chk("t1_gap1", gnt_cyc[2] - gnt_cyc[1], 2);
        // 2: back-pressure fills the buffer, then drains in order
        dec_ready_i = 0;
        do_reset();
        repeat (10) @(posedge clk);
        @(negedge clk);
        chk("t2_req_blocked", imem_req_o, 0);
        chk("t2_grants", gnt_cyc.size(), 2);
        chk("t2_valid", dec_valid_o, 1);
        @(posedge clk);
        #1 dec_ready_i = 1;
        repeat (2) @(posedge clk);
        #1 dec_ready_i = 0;
        chk("t2_pops", popped.size(), 2);
        chk("t2_pop0_pc", popped[0][63:32], 32'h0);
        chk("t2_pop1_pc", popped[1][63:32], 32'h4);
        chk("t2_resume", gnt_cyc.size(), 3);
        // 3: flush while waiting drops the late response and refetches from 0x100
        dec_ready_i = 1; lat = 3;
        do_reset();
        @(posedge clk);
        #1 flush_i = 1; redir = 1; redir_pc = 32'h100;
        @(posedge clk);
        #1 flush_i = 0; redir = 0;
        @(negedge clk);
        chk("t3_valid", dec_valid_o, 0);
        chk("t3_no_req", imem_req_o, 0);
        repeat (10) @(posedge clk);
        #1;
        chk("t3_pops", popped.size(), 1);
        chk("t3_pop0", popped[0], {32'h100, 32'h100 ^ MAGIC});
        // 4: flush coincident with response and pop while one entry is buffered
        dec_ready_i = 0; lat = 1;
        do_reset();
        repeat (3) @(posedge clk);
        #1 flush_i = 1; dec_ready_i = 1;
        @(negedge clk);
        chk("t4_pre_valid", dec_valid_o, 1);
        @(posedge clk);
        #1 flush_i = 0; dec_ready_i = 0;
        @(negedge clk);
        chk("t4_valid", dec_valid_o, 0);
        chk("t4_idle_req", imem_req_o, 1);
        chk("t4_addr", imem_addr_o, 32'h8);
        // 5: grant withheld keeps the request level and address
        imem_gnt_i = 0; dec_ready_i = 1;
        do_reset();
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("t5_req", imem_req_o, 1);
            chk("t5_addr", imem_addr_o, 32'h0);
            chk("t5_pc_en", pc_en_o, 0);
        end
        @(posedge clk);
        #1 imem_gnt_i = 1;
        @(negedge clk);
        chk("t5_accept", pc_en_o, 1);
        // 6: reset while waiting, response lands in IDLE and is ignored
        lat = 2;
        do_reset();
        @(posedge clk);
        #1 reset = 1; imem_gnt_i = 0;
        @(negedge clk);
        chk("t6_rst_pc_en", pc_en_o, 0);
        @(posedge clk);
        #1 reset = 0;
        @(negedge clk);
        chk("t6_rvalid_seen", imem_rvalid_i, 1);
        chk("t6_valid0", dec_valid_o, 0);
        chk("t6_idle_req", imem_req_o, 1);
`ifdef IFETCH_PERF_EN
        chk("t6_perf_fetch", perf_fetch_cnt_o, 0);
        chk("t6_perf_stall", perf_stall_cnt_o, 0);
`endif
        @(negedge clk);
        chk("t6_valid1", dec_valid_o, 0);
        chk_on = 0;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
